i2s_transmitter: RTL and testbench
==================================

# i2s_transmitter

Serialises the signed 24-bit audio samples produced by the sine generator (or any other sample source) into a standard Philips I2S stream for the board's audio codec. It derives `bclk` and `lrclk` from the system clock, so `lrclk` can also clock the upstream generator. Both channel samples are latched once per frame, and `sample_req` pulses at the same moment so upstream stages can advance.

## Interface
- `BITSIZE`, 24: sample width in bits; must be ≤ `SLOTSIZE-1`.
- `SLOTSIZE`, 32: bclk periods per channel slot; frame length is 2*`SLOTSIZE`.
- `BCLKDIV`, 2: clk cycles per bclk half-period; must be ≥ 1.

- `clk`, in, 1: system clock; all logic on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `left_in`, in, `BITSIZE`: left sample, two's complement.
- `right_in`, in, `BITSIZE`: right sample, two's complement.
- `bclk`, out, 1: bit clock, 50% duty, period 2*`BCLKDIV` clk.
- `lrclk`, out, 1: word select; 0 = left slot, 1 = right slot.
- `sdata`, out, 1: serial data, MSB first, changes only on falling `bclk`.
- `sample_req`, out, 1: one-clk pulse when new samples are latched (frame start).

## Operation
- Prescaler `pcnt`, range 0..`BCLKDIV`-1. When `pcnt`==`BCLKDIV`-1, it wraps to 0 and `bclk` toggles.
- A toggle from 1→0 is a *fall event*. Only fall events advance the bit counter `n` (width log2(2*`SLOTSIZE`)), which wraps from 2*`SLOTSIZE`-1 to 0.
- On a fall event, let `n'` be the new count:
  - Set `lrclk` <= `n'`[MSB]. This gives slots 0..`SLOTSIZE`-1 = left.
  - If `n'`==0: latch `left_in` and `right_in` into hold registers and pulse `sample_req` (registered, high for exactly one clk).
  - Let position p = `n'` mod `SLOTSIZE`:
    - For p in 1..`BITSIZE`, `sdata` <= hold[`BITSIZE`-p] of the slot's channel.
    - Otherwise `sdata` <= 0.
  - This is the I2S one-bit delay: the MSB is driven one bclk after the `lrclk` edge, followed by zero padding.
- Inputs are sampled only on the latch cycle. Changes to `left_in`/`right_in` at any other time do not affect the frame in flight.
- Reset values for all outputs and state:
  - `bclk`=0, `lrclk`=1, `sdata`=0, `sample_req`=0
  - `pcnt`=0, `n`=2*`SLOTSIZE`-1, hold registers = 0
- Reset asserted mid-frame: all of the above take their reset values on the next clk edge, with no partial frame completion. The first fall event after release begins a fresh frame with `n'`=0.
- Reset has priority over every other update in the same cycle.

## Timing
- The frame is 2*`SLOTSIZE`*2*`BCLKDIV` clk cycles: 256 at defaults, giving 48 kHz from a 12.288 MHz clk.
- After reset deasserts, the first rising `bclk` is registered at clk edge `BCLKDIV`, and the first fall event at edge 2*`BCLKDIV` (edges counted from 1).
- On the fall event edge, `lrclk`→0 and `sample_req`→1 on the same edge; `sample_req` returns to 0 on the next edge.
- Latch to left MSB on `sdata`: exactly 2*`BCLKDIV` clk (one bclk period).
- Left LSB is driven at p=`BITSIZE`, and `sdata`=0 for p=0 and for p=`BITSIZE`+1..`SLOTSIZE`-1.
- Right MSB is driven one bclk after `lrclk` rises.
- `lrclk` and `sdata` never change in a cycle that is not a fall event. `bclk` changes only when `pcnt` wraps.
- `BCLKDIV`=1: `bclk` toggles every clk and a fall event occurs every 2nd clk. All rules above still hold.

## Test plan
- Reset values: hold `reset` high for 5 clk with random inputs → `bclk`=0, `lrclk`=1, `sdata`=0, `sample_req`=0 on every cycle. After release (defaults), `bclk` first rises at edge 2, and `lrclk` falls with a `sample_req` pulse at edge 4.
- Basic frame: `left_in`=0xA5A5A5, `right_in`=0x5A5A5A.
  - Capture `sdata` on rising `bclk` across one frame.
  - Left bits 1..24 = 0xA5A5A5 MSB first, and bits 0 and 25..31 = 0.
  - Right slot decodes 0x5A5A5A with identical padding, and `lrclk` is high exactly 32 bclks.
- Input isolation: change `left_in` from 0x800000 to 0x7FFFFF at left bit 10 → the current frame still shifts 0x800000, and the next frame shifts 0x7FFFFF.
- Pulse cadence: run 10 frames at defaults → exactly 10 `sample_req` pulses, each one clk wide, spaced 256 clk apart, each coincident with `lrclk` 1→0.
- Reset mid-frame: assert `reset` for 1 clk at right slot bit 7 → next edge shows reset values. After release, the first frame again has its first fall event at edge 2*`BCLKDIV`, with `lrclk`=0 and `n`=0.
- Parameter sweep: `BCLKDIV`=1, `BITSIZE`=16, `SLOTSIZE`=32, `left_in`=0x8001 → `bclk` period 2 clk, frame 128 clk, left bits 1..16 = 0x8001, bits 17..31 = 0.

Source files
------------

// File: rtl/i2s_transmitter.sv
// i2s_transmitter: serialises stereo samples into a Philips I2S stream with derived bclk/lrclk
module i2s_transmitter #(
   parameter int BITSIZE  = 24,
   parameter int SLOTSIZE = 32,
   parameter int BCLKDIV  = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [BITSIZE-1:0] left_in,
   input  logic [BITSIZE-1:0] right_in,
   output logic               bclk,
   output logic               lrclk,
   output logic               sdata,
   output logic               sample_req
);
   localparam int NW = $clog2(2*SLOTSIZE);
   localparam int PW = (BCLKDIV > 1) ? $clog2(BCLKDIV) : 1;
   localparam int BW = (BITSIZE > 1) ? $clog2(BITSIZE) : 1;
   logic [PW-1:0]      pcnt_q, pcnt_d;
   logic [NW-1:0]      n_q, n_d, n_nx, p;
   logic [BW-1:0]      bidx;
   logic [BITSIZE-1:0] left_q, left_d, right_q, right_d;
   logic               bclk_q, bclk_d, lrclk_q, lrclk_d, sdata_q, sdata_d, req_q, req_d;
   logic               wrap, fall, latch;

   // prescaler, fall-event bit counter, slot decode and sample latch
   always_comb begin
      wrap    = pcnt_q == PW'(BCLKDIV-1);
      fall    = wrap & bclk_q;
      n_nx    = (n_q == NW'(2*SLOTSIZE-1)) ? '0 : n_q + 1'b1;
      p       = n_nx[NW-1] ? n_nx - NW'(SLOTSIZE) : n_nx;
      bidx    = BW'(NW'(BITSIZE) - p);
      latch   = fall & (n_nx == '0);
      pcnt_d  = wrap ? '0 : pcnt_q + 1'b1;
      bclk_d  = bclk_q ^ wrap;
      n_d     = fall ? n_nx : n_q;
      lrclk_d = fall ? n_nx[NW-1] : lrclk_q;
      sdata_d = fall ? ((p != '0) && (p <= NW'(BITSIZE)) && (n_nx[NW-1] ? right_q[bidx] : left_q[bidx])) : sdata_q;
      req_d   = latch;
      left_d  = latch ? left_in : left_q;
      right_d = latch ? right_in : right_q;
   end

   // state registers; reset restarts the frame so the next fall event is slot bit 0
   always_ff @(posedge clk) begin
      if (reset) begin
         pcnt_q  <= '0;
         bclk_q  <= 1'b0;
         n_q     <= NW'(2*SLOTSIZE-1);
         lrclk_q <= 1'b1;
         sdata_q <= 1'b0;
         req_q   <= 1'b0;
         left_q  <= '0;
         right_q <= '0;
      end else begin
         pcnt_q  <= pcnt_d;
         bclk_q  <= bclk_d;
         n_q     <= n_d;
         lrclk_q <= lrclk_d;
         sdata_q <= sdata_d;
         req_q   <= req_d;
         left_q  <= left_d;
         right_q <= right_d;
      end
   end

   assign bclk       = bclk_q;
   assign lrclk      = lrclk_q;
   assign sdata      = sdata_q;
   assign sample_req = req_q;
endmodule

// File: tb/tb_i2s_transmitter.sv
// tb_i2s_transmitter: time-based I2S model checked every cycle plus directed frame decodes
module tb_i2s_transmitter;
   logic        clk = 1'b0, reset = 1'b1;
   logic [23:0] l1, r1;
   logic [15:0] l2, r2;
   logic        bclk1, lrclk1, sdata1, req1, bclk2, lrclk2, sdata2, req2;
   int          tests = 0, fails = 0;
   int          k1 = 0, k2 = 0;
   logic [23:0] m_l1 = '0, m_r1 = '0, m_l2 = '0, m_r2 = '0;
   bit          started = 1'b0;
   logic [31:0] lw, rw;
   int          hi;

   always #5 clk = ~clk;

   i2s_transmitter dut1 (
      .clk(clk), .reset(reset), .left_in(l1), .right_in(r1),
      .bclk(bclk1), .lrclk(lrclk1), .sdata(sdata1), .sample_req(req1)
   );

   i2s_transmitter #(.BITSIZE(16), .SLOTSIZE(32), .BCLKDIV(1)) dut2 (
      .clk(clk), .reset(reset), .left_in(l2), .right_in(r2),
      .bclk(bclk2), .lrclk(lrclk2), .sdata(sdata2), .sample_req(req2)
   );

   // latch edges: every 64th fall event, the first one at edge 2*d after reset
   function automatic bit is_latch(int k, int d);
      return k > 0 && k % (2*d) == 0 && ((k / (2*d)) - 1) % 64 == 0;
   endfunction

   // expected {bclk, lrclk, sdata, sample_req} after clk edge k counted from reset release
   function automatic logic [3:0] expect_o(int k, int d, int b, logic [23:0] l, logic [23:0] r);
      int f, n, p;
      logic lr, sd, rq, bc;
      logic [23:0] w;
      f  = k / (2*d);
      bc = 1'((k / d) % 2);
      if (f == 0) return {bc, 3'b100};
      n  = (f - 1) % 64;
      lr = n >= 32;
      p  = n % 32;
      w  = lr ? r : l;
      sd = (p >= 1 && p <= b) ? w[b-p] : 1'b0;
      rq = (k % (2*d) == 0) && n == 0;
      return {bc, lr, sd, rq};
   endfunction

   // model time base and frame sample capture
   always @(posedge clk) begin
      started <= 1'b1;
      k1 <= reset ? 0 : k1 + 1;
      k2 <= reset ? 0 : k2 + 1;
      if (!reset && is_latch(k1 + 1, 2)) begin
         m_l1 <= l1;
         m_r1 <= r1;
      end
      if (!reset && is_latch(k2 + 1, 1)) begin
         m_l2 <= {8'h0, l2};
         m_r2 <= {8'h0, r2};
      end
   end

   // per-cycle compare of both instances against the model
   always @(negedge clk) begin
      if (started) begin
         tests++;
         if ({bclk1, lrclk1, sdata1, req1} !== expect_o(k1, 2, 24, m_l1, m_r1)) begin
            fails++;
            $display("FAIL cycle dut1 k=%0d {bclk,lrclk,sdata,req} got %b expected %b", k1, {bclk1, lrclk1, sdata1, req1}, expect_o(k1, 2, 24, m_l1, m_r1));
         end
         tests++;
         if ({bclk2, lrclk2, sdata2, req2} !== expect_o(k2, 1, 16, m_l2, m_r2)) begin
            fails++;
            $display("FAIL cycle dut2 k=%0d {bclk,lrclk,sdata,req} got %b expected %b", k2, {bclk2, lrclk2, sdata2, req2}, expect_o(k2, 1, 16, m_l2, m_r2));
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_req(input int sel);
      int t;
      t = 0;
      do begin
         tick(1);
         t++;
      end while (!(sel ? req2 : req1) && t < 600);
      if (t >= 600) chk("sample_req timeout", 0, 1);
   endtask

   // release reset and pin the first bclk rise and fall event against literal edges
   task automatic post_release(input string tag);
      reset = 1'b0;
      tick(1); chk({tag, " e1 bclk"}, 32'(bclk1), 0);
      tick(1); chk({tag, " e2 bclk"}, 32'(bclk1), 1);
      tick(1); chk({tag, " e3 lrclk/req"}, 32'({lrclk1, req1}), 32'b10);
      tick(1); chk({tag, " e4 bclk/lrclk/req"}, 32'({bclk1, lrclk1, req1}), 32'b001);
      tick(1); chk({tag, " e5 req"}, 32'(req1), 0);
   endtask

   // decode one frame by sampling sdata at each rising bclk, starting at the next latch
   task automatic capture(input int sel, input int chg_at, input logic [23:0] chg_val,
                          output logic [31:0] lo, output logic [31:0] ro, output int h);
      int rises, t;
      logic pb;
      lo = '0; ro = '0; h = 0; rises = 0; t = 0;
      wait_req(sel);
      pb = sel ? bclk2 : bclk1;
      while (rises < 64 && t < 2000) begin
         tick(1);
         t++;
         if ((sel ? bclk2 : bclk1) && !pb) begin
            if (rises == chg_at) l1 = chg_val;
            if (rises < 32) lo = {lo[30:0], sel ? sdata2 : sdata1};
            else ro = {ro[30:0], sel ? sdata2 : sdata1};
            if (sel ? lrclk2 : lrclk1) h++;
            rises++;
         end
         pb = sel ? bclk2 : bclk1;
      end
      if (rises < 64) chk("capture timeout", 32'(rises), 64);
   endtask

   initial begin
      int cnt, last;
      logic prev_lr;
      l1 = 24'($urandom); r1 = 24'($urandom); l2 = 16'($urandom); r2 = 16'($urandom);
      repeat (5) begin
         tick(1);
         l1 = 24'($urandom); r1 = 24'($urandom); l2 = 16'($urandom); r2 = 16'($urandom);
      end
      chk("reset outputs", 32'({bclk1, lrclk1, sdata1, req1}), 32'b0100);
      l1 = 24'hA5A5A5; r1 = 24'h5A5A5A; l2 = 16'h8001; r2 = 16'h1234;
      post_release("release");

      capture(0, -1, 24'h0, lw, rw, hi);
      chk("basic left slot", lw, 32'h52D2D280);
      chk("basic right slot", rw, 32'h2D2D2D00);
      chk("basic lrclk high bclks", 32'(hi), 32);

      l1 = 24'h800000;
      capture(0, 10, 24'h7FFFFF, lw, rw, hi);
      chk("isolation frame in flight", lw, 32'h40000000);
      capture(0, -1, 24'h0, lw, rw, hi);
      chk("isolation next frame", lw, 32'h3FFFFF80);
      chk("isolation right slot", rw, 32'h2D2D2D00);

      wait_req(0);
      cnt = 0; last = 0; prev_lr = lrclk1;
      for (int i = 1; i <= 2560; i++) begin
         tick(1);
         if (req1) begin
            cnt++;
            chk("pulse spacing", 32'(i - last), 256);
            chk("pulse on lrclk fall", 32'({prev_lr, lrclk1}), 32'b10);
            last = i;
         end
         prev_lr = lrclk1;
      end
      chk("pulse count", 32'(cnt), 10);

      wait_req(0);
      tick(156);
      chk("pre-reset right slot", 32'(lrclk1), 1);
      reset = 1'b1;
      tick(1);
      chk("mid-frame reset outputs", 32'({bclk1, lrclk1, sdata1, req1}), 32'b0100);
      post_release("re-release");

      capture(1, -1, 24'h0, lw, rw, hi);
      chk("sweep left slot", lw, 32'h40008000);
      chk("sweep right slot", rw, 32'h091A0000);
      chk("sweep lrclk high bclks", 32'(hi), 32);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
endmodule
